// File: rtl/nibble_serializer.sv
// MSB-first parallel-to-serial transmitter with valid/ready input and a
// one-entry holding buffer so consecutive words go out with no idle gap.
module nibble_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;
  logic             at_end;

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign at_end   = (state == SHIFT) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept) state_next = SHIFT;
      SHIFT: if (at_end && !hold_full && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // At a word boundary the held word wins; otherwise a same-edge accept
  // bypasses hold and goes straight into the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shifter <= in_data;
            cnt     <= CNT_RELOAD;
          end
        end
        SHIFT: begin
          if (at_end) begin
            if (hold_full) begin
              shifter   <= hold;
              hold_full <= 1'b0;
              cnt       <= CNT_RELOAD;
            end else if (accept) begin
              shifter <= in_data;
              cnt     <= CNT_RELOAD;
            end
          end else begin
            shifter <= {shifter[WIDTH-2:0], 1'b0};
            cnt     <= cnt - CW'(1);
            if (accept) begin
              hold      <= in_data;
              hold_full <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sout = 1'b1;
    busy = 1'b0;
    last = 1'b0;
    if (state == SHIFT) begin
      sout = shifter[WIDTH-1];
      busy = 1'b1;
      last = (cnt == '0);
    end
  end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Parallel-to-serial transmitter that accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first, one bit per clock, onto a single serial line. It sits directly upstream of the four-bit shift register: `sout` connects to the register's serial input. Because the register shifts on every clock, the word sent first (the MSB) lands in register bit WIDTH-1, so the register holds the word as sent one edge after the final bit. A one-entry holding buffer allows back-to-back words with no idle gap.

## Interface
- WIDTH, default 4: word width and bits per frame. Legal range is 2 to 16. The default 4 matches the downstream shift register.
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high. It takes priority over every other input.
- in_data  in  WIDTH  word to transmit. Sampled when in_valid && in_ready at a rising edge.
- in_valid  in  1  upstream has a word on in_data.
- in_ready  out  1  the holding buffer is empty, so a word can be accepted this cycle.
- sout  out  1  registered serial output. It is 1 when idle.
- busy  out  1  the shifter is emitting a word.
- last  out  1  sout carries bit 0 (LSB) of the current word in this cycle.

## Operation
- Registers:
  - shifter, WIDTH bits.
  - bit counter, $clog2(WIDTH) bits.
  - hold register, WIDTH bits, plus a hold_full flag.
  - state, one of IDLE or SHIFT.
- Reset values: sout=1, busy=0, last=0, in_ready=1, hold_full=0, state=IDLE. Shifter and counter contents are don't-care.
- in_ready = !hold_full. It is combinational from the flag and never depends on in_valid.
- IDLE:
  - On accept, load in_data into the shifter, set the counter to WIDTH-1 and go to SHIFT.
  - The hold register stays empty.
  - sout=1 for as long as the block stays in IDLE.
- SHIFT:
  - Each cycle, sout = shifter MSB. At each edge the shifter shifts left and the counter decrements.
  - last = (counter == 0).
- End of word (edge while last=1):
  - If hold_full: move hold to the shifter, clear hold_full, reload the counter, stay in SHIFT.
  - Else, if an accept occurs at this same edge: load in_data straight into the shifter (bypass) and stay in SHIFT.
  - Else: go to IDLE.
- Accept in SHIFT, not at the end of a word: the word goes into hold and hold_full is set.
- A word accepted at the same edge that hold is drained goes into the now-empty hold. This cannot happen, because in_ready was 0 in that cycle; the bench asserts it never occurs.
- Words are emitted in acceptance order. None are dropped or duplicated.
- If in_valid is asserted with in_ready=0, there is no effect. Upstream must hold in_data stable until it is accepted.

## Timing
- Word accepted at edge T0:
  - Bit WIDTH-1 is on sout from T0 to T1.
  - Bit 0 is on sout from T0+WIDTH-1 to T0+WIDTH, with last=1 in that cycle.
  - The downstream register holds the full word after edge T0+WIDTH.
- Latency from accept to first bit: 1 cycle. Throughput: one word per WIDTH cycles, sustained, with no gap.
- busy is high exactly from T0 to T0+WIDTH for a single word. Back-to-back words keep it high continuously.
- rst mid-word: at the next edge sout=1, busy=0, last=0, in_ready=1. The word being shifted and any held word are discarded, and the partial frame is not completed.
- rst and in_valid at the same edge: the word is not accepted.

## Test plan
- Reset: assert rst for 2 edges with in_valid=1 -> sout=1, busy=0, last=0, in_ready=1 throughout and the cycle after release; nothing accepted.
- Single word 4'b1010 at T0 -> sout 1,0,1,0 in cycles T0..T0+3, last only in the 4th cycle, then sout=1 idle. The downstream 4-bit shift register reads 4'b1010 after edge T0+4.
- Back-to-back 4'hC then 4'h3 with in_valid held -> sout 1,1,0,0,0,0,1,1 over 8 contiguous cycles, busy never drops, last high in cycles 4 and 8.
- Backpressure with 4'h9, 4'h6, 4'hF offered continuously -> in_ready=0 while hold is full; the third word is accepted only after the first word's last cycle. Serial stream is 1001 0110 1111, no loss or duplication.
- Reset during the 2nd bit of 4'h5 with 4'hA held -> next cycle sout=1, busy=0, in_ready=1. Neither remaining bits nor 4'hA appear. A new 4'h3 afterward emits 0,0,1,1.
- WIDTH=8, word 8'hA5 -> sout 1,0,1,0,0,1,0,1, last in the 8th cycle, then idle 1.
